// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor (2-bit BHT + tagged BTB) with misprediction redirect/flush sequencer.
// Optional gshare indexing enabled by defining BPRED_GSHARE_EN.
module branch_predict_ctrl #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int IDX_BITS          = 6,
  parameter int FLUSH_CYCLES      = 2,
  parameter int HIST_BITS         = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_DATA_LENGTH-1:0] if_pc,
  output logic                         Predicted,
  output logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
  input  logic                         Execute,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc,
  input  logic                         ex_taken,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
  input  logic [1:0]                   Result,
  output logic                         flush,
  output logic                         redirect_valid,
  output logic [WIDTH_DATA_LENGTH-1:0] redirect_pc
);

  localparam int W       = WIDTH_DATA_LENGTH;
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = W - IDX_BITS - 2;
  localparam int CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if ((FLUSH_CYCLES < 1) || (HIST_BITS < 2) || (HIST_BITS > IDX_BITS)) begin : g_bad_param
    $error("branch_predict_ctrl: illegal FLUSH_CYCLES/HIST_BITS");
  end

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_count, w_count_next;
  logic                 r_flush, w_flush_next;
  logic                 r_redirect_valid, w_redirect_valid_next;
  logic [W-1:0]         r_redirect_pc, w_redirect_pc_next;

  logic [1:0]           r_bht [ENTRIES];
  logic [ENTRIES-1:0]   r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag [ENTRIES];
  logic [W-1:0]         r_btb_target [ENTRIES];

  logic [IDX_BITS-1:0]  w_if_idx, w_ex_idx;
  logic                 w_hit, w_update, w_mispredict;
  logic [1:0]           w_bht_cur, w_bht_upd;
  logic                 w_unused;

  assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

`ifdef BPRED_GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;

  // Both indexes use the pre-shift history; the shift lands on the same edge as training.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ghr <= '0;
    else if (w_update) r_ghr <= {r_ghr[HIST_BITS-2:0], ex_taken};
  end

  assign w_if_idx = if_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
  assign w_ex_idx = ex_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
`else
  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
`endif

  assign w_hit     = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == if_pc[W-1:IDX_BITS+2]);
  assign Predicted = w_hit && r_bht[w_if_idx][1];
  assign PC_Pre    = Predicted ? r_btb_target[w_if_idx] : (if_pc + W'(4));

  // Wrong-path resolutions arriving while flushing must not train or redirect.
  assign w_update     = Execute && (Result != 2'b00) && (r_state == S_IDLE);
  assign w_mispredict = w_update && Result[1];

  assign w_bht_cur = r_bht[w_ex_idx];
  assign w_bht_upd = ex_taken ? ((w_bht_cur == 2'b11) ? 2'b11 : w_bht_cur + 2'b01)
                              : ((w_bht_cur == 2'b00) ? 2'b00 : w_bht_cur - 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= 2'b01;
      r_btb_valid <= '0;
    end else if (w_update) begin
      r_bht[w_ex_idx] <= w_bht_upd;
      if (ex_taken) r_btb_valid[w_ex_idx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_update && ex_taken) begin
      r_btb_tag[w_ex_idx]    <= ex_pc[W-1:IDX_BITS+2];
      r_btb_target[w_ex_idx] <= PC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_count          <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_state_next;
      r_count          <= w_count_next;
      r_flush          <= w_flush_next;
      r_redirect_valid <= w_redirect_valid_next;
      r_redirect_pc    <= w_redirect_pc_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_count_next          = r_count;
    w_flush_next          = r_flush;
    w_redirect_valid_next = 1'b0;
    w_redirect_pc_next    = r_redirect_pc;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_state_next          = S_FLUSH;
          w_redirect_valid_next = 1'b1;
          w_redirect_pc_next    = PC_ALU;
          w_flush_next          = 1'b1;
          w_count_next          = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (r_count == '0) begin
          w_state_next = S_IDLE;
          w_flush_next = 1'b0;
        end else begin
          w_count_next = r_count - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Randomised + directed bench for branch_predict_ctrl against a table-level reference model.
module tb_branch_predict_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, ex_pc, PC_ALU, PC_Pre, redirect_pc;
  logic        Predicted, Execute, ex_taken, flush, redirect_valid;
  logic [1:0]  Result;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  branch_predict_ctrl #(.WIDTH_DATA_LENGTH(32), .IDX_BITS(6), .FLUSH_CYCLES(FC), .HIST_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .Predicted(Predicted), .PC_Pre(PC_Pre),
    .Execute(Execute), .ex_pc(ex_pc), .ex_taken(ex_taken), .PC_ALU(PC_ALU), .Result(Result),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference model: counters as integers, BTB as arrays, flush as "cycles still to go".
  int          m_bht [64];
  bit          m_val [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_left;
  bit          m_rv;
  logic [31:0] m_rpc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit exp_pred(input logic [31:0] pc);
    int k = idx_of(pc);
    return m_val[k] && (m_tag[k] == (pc >> 8)) && (m_bht[k] >= 2);
  endfunction

  function automatic logic [31:0] exp_pcpre(input logic [31:0] pc);
    return exp_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        m_bht[i] <= 1;
        m_val[i] <= 1'b0;
      end
      m_left <= 0;
      m_rv   <= 1'b0;
      m_rpc  <= 32'h0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_rv   <= 1'b0;
    end else begin
      m_rv <= 1'b0;
      if (Execute && Result != 2'b00) begin
        m_bht[idx_of(ex_pc)] <= ex_taken ? ((m_bht[idx_of(ex_pc)] < 3) ? m_bht[idx_of(ex_pc)] + 1 : 3)
                                         : ((m_bht[idx_of(ex_pc)] > 0) ? m_bht[idx_of(ex_pc)] - 1 : 0);
        if (ex_taken) begin
          m_val[idx_of(ex_pc)] <= 1'b1;
          m_tag[idx_of(ex_pc)] <= ex_pc >> 8;
          m_tgt[idx_of(ex_pc)] <= PC_ALU;
        end
        if (Result >= 2'd2) begin
          m_rv   <= 1'b1;
          m_rpc  <= PC_ALU;
          m_left <= FC;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("Predicted",      32'(Predicted),      32'(exp_pred(if_pc)));
      check("PC_Pre",         PC_Pre,              exp_pcpre(if_pc));
      check("flush",          32'(flush),          32'(m_left > 0));
      check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      check("redirect_pc",    redirect_pc,         m_rpc);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] alu, input logic [1:0] res);
    Execute = 1'b1; ex_pc = pc; ex_taken = tk; PC_ALU = alu; Result = res;
    cyc();
    Execute = 1'b0; Result = 2'b00;
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input bit pred, input logic [31:0] pre);
    if_pc = pc;
    #1;
    check({nm, "_pred"}, 32'(Predicted), 32'(pred));
    check({nm, "_pcpre"}, PC_Pre, pre);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h1234_0000; Execute = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    PC_ALU = '0; Result = 2'b00;
    repeat (3) cyc();
    look("reset", 32'h1234_0000, 1'b0, 32'h1234_0004);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_rv", 32'(redirect_valid), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Mispredict: registered redirect, then flush for FC cycles while EX is ignored.
    train(32'h100, 1'b1, 32'h200, 2'b10);
    check("mp_rv", 32'(redirect_valid), 32'd1);
    check("mp_rpc", redirect_pc, 32'h200);
    check("mp_flush0", 32'(flush), 32'd1);
    Execute = 1'b1; ex_pc = 32'h100; ex_taken = 1'b0; PC_ALU = 32'h1234_FFFF; Result = 2'b10;
    cyc();
    check("fl_rv", 32'(redirect_valid), 32'd0);
    check("fl_flush1", 32'(flush), 32'd1);
    cyc();
    check("fl_flush2", 32'(flush), 32'd0);
    check("fl_rpc", redirect_pc, 32'h200);
    Execute = 1'b0; Result = 2'b00;
    cyc();
    check("fl_norv", 32'(redirect_valid), 32'd0);

    // Second taken with a correct prediction: no flush, strong taken.
    train(32'h100, 1'b1, 32'h200, 2'b01);
    check("ok_flush", 32'(flush), 32'd0);
    look("trained", 32'h100, 1'b1, 32'h200);
    look("alias", 32'h1100, 1'b0, 32'h1104);

    // Saturation on a separate index.
    repeat (5) train(32'h344, 1'b1, 32'h500, 2'b01);
    look("sat_hi", 32'h344, 1'b1, 32'h500);
    train(32'h344, 1'b0, 32'h348, 2'b01);
    look("sat_wt", 32'h344, 1'b1, 32'h500);
    repeat (5) train(32'h344, 1'b0, 32'h348, 2'b01);
    look("sat_lo", 32'h344, 1'b0, 32'h348);
    train(32'h344, 1'b1, 32'h500, 2'b01);
    look("nowrap1", 32'h344, 1'b0, 32'h348);
    train(32'h344, 1'b1, 32'h500, 2'b01);
    look("nowrap2", 32'h344, 1'b1, 32'h500);

    // Reserved result code behaves as a mispredict.
    train(32'h200, 1'b0, 32'h204, 2'b11);
    check("res11_rv", 32'(redirect_valid), 32'd1);
    check("res11_rpc", redirect_pc, 32'h204);
    repeat (3) cyc();

    // Reset in the first flush cycle aborts at once.
    train(32'h100, 1'b1, 32'h200, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rstmid_flush", 32'(flush), 32'd0);
    check("rstmid_rv", 32'(redirect_valid), 32'd0);
    look("rstmid", 32'h100, 1'b0, 32'h104);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 399) != 0);
      if_pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      ex_pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      Execute  = 1'($urandom_range(0, 1));
      ex_taken = 1'($urandom_range(0, 1));
      PC_ALU   = $urandom;
      Result   = 2'($urandom_range(0, 3));
      cyc();
    end
    rst_n = 1'b1;
    Execute = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
